// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and constants for the four-master round-robin bus arbiter.
package bus_arb_pkg;

    localparam int NUM_M = 4;
    localparam int ID_W  = 2;

    // last_id reset value: the search starts at last_id+1, so master 0 is first after reset
    localparam logic [ID_W-1:0] LAST_ID_RST = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Master index to one-hot grant vector
    function automatic logic [NUM_M-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_pick.sv
// Round-robin picker: first set request bit at or after the start pointer, wrapping mod 4.
module bus_rr_pick
    import bus_arb_pkg::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             hit,
    output logic [ID_W-1:0]  id
);

    logic [NUM_M-1:0] rot_s;
    logic [ID_W-1:0]  off_s;

    // Rotate requests so the start pointer lands on bit 0, then priority-encode the offset
    always_comb begin
        rot_s = NUM_M'({req, req} >> start);
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        hit = |req;
        id  = start + off_s;
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter with registered one-hot grants.
// Define BUS_ARB_TIMEOUT_EN to enable the HOLD_MAX hold limit with forced rotation;
// without it the owner keeps the bus until it drops its request.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] m_req,
    output logic [NUM_M-1:0] m_grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid,
    output logic [7:0]       hold_cnt
);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

    arb_state_e       state_r;
    logic [ID_W-1:0]  last_id_r;
    logic [NUM_M-1:0] grant_r;
    logic [ID_W-1:0]  grant_id_r;
    logic             grant_valid_r;
    logic [7:0]       hold_cnt_r;

    logic [ID_W-1:0]  start_s;
    logic [NUM_M-1:0] oth_req_s;
    logic             full_hit_s;
    logic [ID_W-1:0]  full_id_s;
    logic             oth_hit_s;
    logic [ID_W-1:0]  oth_id_s;
    logic             owner_req_s;
    logic             timeout_s;
    logic [7:0]       hold_inc_s;

    assign start_s     = last_id_r + 2'd1;
    assign oth_req_s   = m_req & ~grant_r;
    assign owner_req_s = m_req[grant_id_r];
    assign hold_inc_s  = (hold_cnt_r == 8'hFF) ? 8'hFF : hold_cnt_r + 8'd1;
    // At or past the limit (counter may have run on while nobody else was waiting)
    assign timeout_s   = TIMEOUT_EN & owner_req_s & (hold_cnt_r >= HOLD_LIM) & oth_hit_s;

    bus_rr_pick u_pick_full (
        .req   (m_req),
        .start (start_s),
        .hit   (full_hit_s),
        .id    (full_id_s)
    );

    bus_rr_pick u_pick_oth (
        .req   (oth_req_s),
        .start (start_s),
        .hit   (oth_hit_s),
        .id    (oth_id_s)
    );

    // Arbitration FSM: grant, handoff, forced rotation and hold counting, all registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            last_id_r     <= LAST_ID_RST;
            grant_r       <= {NUM_M{1'b0}};
            grant_id_r    <= {ID_W{1'b0}};
            grant_valid_r <= 1'b0;
            hold_cnt_r    <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (full_hit_s) begin
                        state_r       <= OWN;
                        last_id_r     <= full_id_s;
                        grant_r       <= id_to_onehot(full_id_s);
                        grant_id_r    <= full_id_s;
                        grant_valid_r <= 1'b1;
                        hold_cnt_r    <= 8'd0;
                    end else begin
                        state_r       <= IDLE;
                        grant_r       <= {NUM_M{1'b0}};
                        grant_id_r    <= {ID_W{1'b0}};
                        grant_valid_r <= 1'b0;
                        hold_cnt_r    <= 8'd0;
                    end
                end
                OWN: begin
                    if (!owner_req_s) begin
                        if (full_hit_s) begin
                            // Direct handoff, no dead cycle
                            state_r       <= OWN;
                            last_id_r     <= full_id_s;
                            grant_r       <= id_to_onehot(full_id_s);
                            grant_id_r    <= full_id_s;
                            grant_valid_r <= 1'b1;
                            hold_cnt_r    <= 8'd0;
                        end else begin
                            state_r       <= IDLE;
                            grant_r       <= {NUM_M{1'b0}};
                            grant_id_r    <= {ID_W{1'b0}};
                            grant_valid_r <= 1'b0;
                            hold_cnt_r    <= 8'd0;
                        end
                    end else if (timeout_s) begin
                        // Forced rotation to the next waiting master other than the owner
                        state_r       <= OWN;
                        last_id_r     <= oth_id_s;
                        grant_r       <= id_to_onehot(oth_id_s);
                        grant_id_r    <= oth_id_s;
                        grant_valid_r <= 1'b1;
                        hold_cnt_r    <= 8'd0;
                    end else begin
                        state_r       <= OWN;
                        hold_cnt_r    <= hold_inc_s;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    grant_r       <= {NUM_M{1'b0}};
                    grant_id_r    <= {ID_W{1'b0}};
                    grant_valid_r <= 1'b0;
                    hold_cnt_r    <= 8'd0;
                end
            endcase
        end
    end

    assign m_grant     = grant_r;
    assign grant_id    = grant_id_r;
    assign grant_valid = grant_valid_r;
    assign hold_cnt    = hold_cnt_r;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios, a random run, and a
// cycle-by-cycle comparison against an owner/last/hold model of the arbitration rules.
module tb_bus_rr_arbiter;

    localparam int HOLD_MAX = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] m_req = 4'b0000;
    logic [3:0] m_grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic [7:0] hold_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: owner index (-1 = idle), last winner, hold cycles
    int mo = -1;
    int ml = 3;
    int mh = 0;

    bus_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_req       (m_req),
        .m_grant     (m_grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .hold_cnt    (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int s);
        for (int k = 0; k < 4; k++) begin
            if (r[(s + k) % 4]) return (s + k) % 4;
        end
        return -1;
    endfunction

    // Reference model of the arbitration rules
    always @(posedge clk or negedge reset_n) begin
        int p;
        logic [3:0] others;
        if (!reset_n) begin
            mo = -1; ml = 3; mh = 0;
        end else if (mo < 0 || !m_req[mo]) begin
            p = pick(m_req, (ml + 1) % 4);
            if (p >= 0) begin mo = p; ml = p; mh = 0; end
            else begin mo = -1; mh = 0; end
        end else begin
            others = m_req;
            others[mo] = 1'b0;
            p = pick(others, (ml + 1) % 4);
            if (TO_EN && mh >= HOLD_MAX - 1 && p >= 0) begin mo = p; ml = p; mh = 0; end
            else mh = (mh < 255) ? mh + 1 : 255;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            chk("m_grant", int'(m_grant), (mo >= 0) ? (1 << mo) : 0);
            chk("grant_valid", int'(grant_valid), (mo >= 0) ? 1 : 0);
            chk("onehot0", int'($onehot0(m_grant)), 1);
            chk("valid_or", int'(grant_valid), int'(|m_grant));
            if (mo >= 0) begin
                chk("grant_id", int'(grant_id), mo);
                chk("hold_cnt", int'(hold_cnt), mh);
            end
        end
    end

    // One cycle with the given request vector; returns 1 time unit after the edge
    task automatic cyc(input logic [3:0] r);
        m_req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_o;
        // Reset state
        #12;
        chk("rst_grant", int'(m_grant), 0);
        chk("rst_valid", int'(grant_valid), 0);
        chk("rst_id", int'(grant_id), 0);
        chk("rst_hold", int'(hold_cnt), 0);
        #11 reset_n = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // All four request continuously: rotation every HOLD_MAX cycles (or master 0 forever)
        for (int c = 1; c <= 33; c++) begin
            cyc(4'b1111);
            if (c % 8 == 0 || c % 8 == 1) begin
                exp_o = TO_EN ? ((c - 1) / 8) % 4 : 0;
                chk("rot_grant", int'(m_grant), 1 << exp_o);
            end
        end
        cyc(4'b0000);
        chk("idle_after_rot", int'(grant_valid), 0);

        // Master 2 alone for three cycles, then release to idle
        for (int c = 0; c < 3; c++) begin
            cyc(4'b0100);
            chk("m2_grant", int'(m_grant), 4);
            chk("m2_id", int'(grant_id), 2);
        end
        cyc(4'b0000);
        chk("m2_release", int'(m_grant), 0);

        // Master 1 owns, drops while 3 and 0 raise: handoff to 3 with no idle cycle
        cyc(4'b0010);
        chk("m1_grant", int'(m_grant), 2);
        cyc(4'b1001);
        chk("handoff_grant", int'(m_grant), 8);
        chk("handoff_valid", int'(grant_valid), 1);
        cyc(4'b0000);

        // Lone requester is never rotated away; hold counter keeps counting
        for (int c = 0; c < 20; c++) cyc(4'b0100);
        chk("lone_grant", int'(m_grant), 4);
        chk("lone_hold", int'(hold_cnt), 19);

        // Handoff to master 3, then asynchronous reset mid-grant
        cyc(4'b1000);
        chk("m3_grant", int'(m_grant), 8);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_grant", int'(m_grant), 0);
        chk("async_rst_valid", int'(grant_valid), 0);
        m_req = 4'b1010;
        #1 reset_n = 1'b1;
        cyc(4'b1010);
        chk("post_rst_grant", int'(m_grant), 2);
        chk("post_rst_id", int'(grant_id), 1);

        // Random request run, checked by the compare process
        for (int c = 0; c < 300; c++) begin
            cyc(4'($urandom_range(0, 15)));
        end
        cyc(4'b0000);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
